// File: rtl/fir_pkg.sv
// Shared width math and the round-half-up / saturate helper used by the FIR output stage.
package fir_pkg;

  localparam int MAX_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int accWidth(input int dataW, input int coefW, input int taps);
    return dataW + coefW + clog2(taps);
  endfunction

  // Works on a wide sign-extended copy so the rounding add can never wrap.
  function automatic logic signed [MAX_W-1:0] roundSat(
    input logic signed [MAX_W-1:0] acc,
    input int                      shift,
    input int                      outW
  );
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] maxV;
    logic signed [MAX_W-1:0] minV;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    r = acc;
    if (shift > 0) r = r + (one <<< (shift - 1));
    r = r >>> shift;
    maxV = (one <<< (outW - 1)) - one;
    minV = -(one <<< (outW - 1));
    if (r > maxV) r = maxV;
    else if (r < minV) r = minV;
    return r;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered signed sum of TAPS operands with a valid flag; one cycle of latency.
module fir_adder_tree import fir_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int TAPS  = 8,
  parameter int SUM_W = IN_W + clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  operands_i [TAPS],
  output logic signed [SUM_W-1:0] sum_o,
  output logic                    valid_o
);

  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;
  logic                    valid_q;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++)
      sum_d = sum_d + {{(SUM_W-IN_W){operands_i[k][IN_W-1]}}, operands_i[k]};
  end

  // clear_i only drops the valid flag; the stale sum is never observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      sum_q   <= sum_d;
      valid_q <= valid_i;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fir_filter_param.sv
// Three-stage pipelined FIR (multiply, sum, round/saturate) with double-buffered coefficients
// and valid/ready handshaking on both sides.
module fir_filter_param import fir_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 20,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic signed [OUT_W-1:0]   data_out,
  output logic                      valid_out,
  input  logic                      ready_out,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  input  logic                      coef_commit,
  input  logic                      flush
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = accWidth(DATA_W, COEF_W, TAPS);

  if (TAPS < 2 || TAPS > 32) begin : g_badTaps
    $error("fir_filter_param: TAPS must be in 2..32");
  end
  if (DATA_W < 2 || COEF_W < 2 || OUT_W < 2) begin : g_badWidth
    $error("fir_filter_param: DATA_W, COEF_W and OUT_W must be at least 2");
  end
  if (ACC_W > MAX_W - 2) begin : g_badAcc
    $error("fir_filter_param: accumulator too wide for the rounding helper");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_badShift
    $error("fir_filter_param: SHIFT must be in 0..ACC_W-1");
  end

  logic signed [DATA_W-1:0] xLine_q  [TAPS];
  logic signed [DATA_W-1:0] xNew     [TAPS];
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] shadow_d [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic signed [PROD_W-1:0] prod_q   [TAPS];
  logic signed [PROD_W-1:0] prod_d   [TAPS];
  logic                     valid1_q;
  logic signed [ACC_W-1:0]  accSum;
  logic                     valid2;
  logic signed [MAX_W-1:0]  accExt;
  logic signed [OUT_W-1:0]  dataOut_d;
  logic signed [OUT_W-1:0]  dataOut_q;
  logic                     validOut_q;
  logic                     stall;
  logic                     accept;

  assign stall    = validOut_q && !ready_out;
  assign ready_in = !stall && !flush;
  assign accept   = valid_in && ready_in;

  // Products use the shifted-in view of the delay line so stage 1 lands on the accept edge.
  always_comb begin
    xNew[0] = data_in;
    for (int k = 1; k < TAPS; k++) xNew[k] = xLine_q[k-1];
    for (int k = 0; k < TAPS; k++)
      prod_d[k] = $signed({{COEF_W{xNew[k][DATA_W-1]}}, xNew[k]}) *
                  $signed({{DATA_W{active_q[k][COEF_W-1]}}, active_q[k]});
  end

  // The shadow next-state feeds the commit too, so a same-cycle write is included.
  always_comb begin
    for (int k = 0; k < TAPS; k++) shadow_d[k] = shadow_q[k];
    if (coef_we && int'(coef_addr) < TAPS) shadow_d[coef_addr] = coef_wdata;
  end

  always_comb begin
    accExt    = {{(MAX_W-ACC_W){accSum[ACC_W-1]}}, accSum};
    dataOut_d = OUT_W'(roundSat(accExt, SHIFT, OUT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        xLine_q[k]  <= '0;
        prod_q[k]   <= '0;
        shadow_q[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
        active_q[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
      end
      valid1_q   <= 1'b0;
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (coef_commit) active_q <= shadow_d;
      if (flush) begin
        for (int k = 0; k < TAPS; k++) xLine_q[k] <= '0;
        valid1_q   <= 1'b0;
        validOut_q <= 1'b0;
      end else if (!stall) begin
        if (accept) begin
          xLine_q <= xNew;
          prod_q  <= prod_d;
        end
        valid1_q   <= accept;
        validOut_q <= valid2;
        if (valid2) dataOut_q <= dataOut_d;
      end
    end
  end

  fir_adder_tree #(
    .IN_W  (PROD_W),
    .TAPS  (TAPS),
    .SUM_W (ACC_W)
  ) u_adderTree (
    .clk        (clk),
    .rst        (rst),
    .en_i       (!stall),
    .clear_i    (flush),
    .valid_i    (valid1_q),
    .operands_i (prod_q),
    .sum_o      (accSum),
    .valid_o    (valid2)
  );

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;

endmodule
